iter_divider: RTL
=================

ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 4..64.
REQ-002 clock  input  1  rising-edge clock; only clock in the block.
REQ-003 clear  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  numerator; captured on accepted start.
REQ-006 divisor  input  WIDTH  denominator; captured on accepted start.
REQ-007 signed_mode  input  1  1 = two's-complement operands; present only with DIV_SIGNED_EN.
REQ-008 busy  output  1  high from the accepting edge until done is high.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  WIDTH  result quotient.
REQ-011 remainder  output  WIDTH  result remainder.
REQ-012 div_by_zero  output  1  divisor was zero; valid with done.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE.
REQ-014 IDLE with start=1 at edge k: capture operands, busy=1, go to CALC; operands are not sampled in any other state or cycle.
REQ-015 CALC: non-restoring algorithm, one quotient bit per edge, add or subtract selected by the sign of the partial remainder; exactly WIDTH iterations at edges k+1..k+WIDTH, then FIX.
REQ-016 FIX: if the partial remainder is negative, add the divisor back once; apply the sign correction (REQ-021); go to DONE.
REQ-017 Latency: done=1 in the cycle after edge k+WIDTH+1; busy=0 in that cycle; next edge returns to IDLE.
REQ-018 quotient, remainder and div_by_zero hold their values from done until the next accepted start.
REQ-019 start while busy is ignored; no queueing.
REQ-020 Divisor zero at capture: skip CALC and FIX and enter DONE at edge k; quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 Signed operation divides magnitudes. Quotient is truncated toward zero and negated when operand signs differ. Remainder takes the dividend's sign.
REQ-022 Signed most-negative divided by -1: quotient=most-negative, remainder=0, div_by_zero=0 (wrap, no flag).
REQ-023 start may be held high: a new operation is accepted at the first edge back in IDLE.

Reset
REQ-024 clear=1 at any edge, including mid-operation: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
REQ-025 clear has priority over start at the same edge.

Configuration
REQ-026 Macro DIV_SIGNED_EN defined: signed_mode port exists and REQ-021/022 apply when signed_mode=1.
REQ-027 Macro DIV_SIGNED_EN undefined: no signed_mode port and no sign logic; all operands are unsigned; latency is unchanged.

Structure
REQ-028 Shared package div_pkg holds the FSM state typedef, the default WIDTH constant and the counter-width function (clog2 of WIDTH+1).
REQ-029 One sub-module div_addsub_step: WIDTH+1-bit add/subtract of partial remainder and divisor, plus next quotient bit; instantiated once.

Verification (WIDTH=8)
REQ-030 Unsigned 100/7, start one cycle -> done 10 cycles later (WIDTH+2 edges after start edge inclusive), quotient=14, remainder=2, div_by_zero=0.
REQ-031 Divide 7 by 0 -> done in the cycle after the accepting edge, quotient=0xFF, remainder=0x07, div_by_zero=1.
REQ-032 Signed (DIV_SIGNED_EN) -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100/-7 -> quotient=0xF2, remainder=0x02.
REQ-033 Signed -128/-1 -> quotient=0x80, remainder=0x00, div_by_zero=0.
REQ-034 Start 200/3, pulse start again with 9/2 at the 3rd busy cycle -> single done, quotient=66, remainder=2; second request not executed.
REQ-035 Assert clear at the 4th CALC cycle -> next cycle busy=0, done=0, outputs 0. A new start 50/5 then yields quotient=10, remainder=0 at normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Signed operation is enabled with DIV_SIGNED_EN.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_addsub_step.sv
// One non-restoring iteration: shift, add or subtract divisor,
// and produce the next quotient bit.
module div_addsub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] opnd;

  // The dropped top bit is harmless: the result always fits WIDTH+1 bits.
  assign shifted = {rem_i[WIDTH-1:0], bit_i};
  assign opnd    = {1'b0, dvs_i};
  assign rem_o   = rem_i[WIDTH] ? shifted + opnd : shifted - opnd;
  assign q_o     = ~rem_o[WIDTH];

endmodule

// File: rtl/iter_divider.sv
// Iterative non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the signed_mode port and sign handling.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             a_neg, b_neg;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_addsub_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (quo_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    a_neg   = signed_mode & dividend[WIDTH-1];
    b_neg   = signed_mode & divisor[WIDTH-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
`else
    a_mag   = dividend;
    b_mag   = divisor;
`endif
    rem_fix = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q
                           : rem_q[WIDTH-1:0];
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
`endif
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef DIV_SIGNED_EN
        quot_d  = qneg_q ? -quo_q : quo_q;
        rmd_d   = rneg_q ? -rem_fix : rem_fix;
`else
        quot_d  = quo_q;
        rmd_d   = rem_fix;
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
